// File: rtl/ram_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ram_pkg
//  Description : Shared types and helpers for the clearable simple dual-port
//                RAM: clear-sweep FSM state type, collision-mode encodings and
//                an address-width helper that never returns zero.
//  Revision    : 1.0  initial release
// ============================================================================
package ram_pkg;

    // Clear-sweep controller states
    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } clr_state_t;

    // Write-to-read collision behaviour, selected by the BYPASS parameter
    localparam int COLL_READ_FIRST  = 0;
    localparam int COLL_WRITE_FIRST = 1;

    // $clog2 returns 0 for a depth of 1; keep at least one address bit
    function automatic int clog2_safe(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ram_sdp_core.sv
`default_nettype none
// ============================================================================
//  Module      : ram_sdp_core
//  Description : Bare storage array with one write port and one registered
//                read stage. The read stage also handles the same-edge
//                write/read collision (old word or forwarded new word) and
//                returns zero for reads flagged as out of range.
//  Ports       : clock, reset      - clock / synchronous active-high reset
//                wr_en/wr_addr/wr_data - already-qualified write request
//                rd_en/rd_addr     - accepted read request (stage-1 regs)
//                rd_zero           - stage-1 address is outside the array
//                rd_data/rd_valid  - registered read result
//  Revision    : 1.0  initial release
// ============================================================================
module ram_sdp_core
    import ram_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = 10,
    parameter int BYPASS = 0
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic signed [WIDTH-1:0]  wr_data,
    input  logic                     rd_en,
    input  logic [ADDR_W-1:0]        rd_addr,
    input  logic                     rd_zero,
    output logic signed [WIDTH-1:0]  rd_data,
    output logic                     rd_valid
);

    localparam bit c_forward = (BYPASS == COLL_WRITE_FIRST);

    logic signed [WIDTH-1:0] mem [DEPTH];
    logic                    w_fwd;

    // The caller only asserts wr_en for in-range addresses
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign w_fwd = c_forward && wr_en && (wr_addr == rd_addr);

    // rd_data keeps its last value on idle cycles rather than zeroing
    always_ff @(posedge clock) begin
        if (reset) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) begin
                if (rd_zero) begin
                    rd_data <= '0;
                end else if (w_fwd) begin
                    rd_data <= wr_data;
                end else begin
                    rd_data <= mem[rd_addr];
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/ram_sdp_clr.sv
`default_nettype none
// ============================================================================
//  Module      : ram_sdp_clr
//  Description : Parametrised simple dual-port RAM with a hardware clear
//                sweep. A single-cycle clear_req (or reset) walks every word
//                writing CLEAR_VAL, one word per cycle, while external writes
//                and new reads are locked out. Read latency is 2 cycles, or 3
//                with OUT_REG=1; rd_valid accompanies the data.
//  Ports       : clock, reset   - clock / synchronous active-high reset
//                clear_req, busy - start a clear sweep / sweep in progress
//                wr_en, wr_addr, data_in - write port
//                rd_en, rd_addr  - read request
//                data_out, rd_valid - read result
//  Revision    : 1.0  initial release
// ============================================================================
module ram_sdp_clr
    import ram_pkg::*;
#(
    parameter int                      WIDTH     = 8,
    parameter int                      DEPTH     = 1024,
    parameter int                      ADDR_W    = clog2_safe(DEPTH),
    parameter int                      OUT_REG   = 0,
    parameter int                      BYPASS    = 0,
    parameter logic signed [WIDTH-1:0] CLEAR_VAL = '0
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     clear_req,
    output logic                     busy,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic signed [WIDTH-1:0]  data_in,
    input  logic                     rd_en,
    input  logic [ADDR_W-1:0]        rd_addr,
    output logic signed [WIDTH-1:0]  data_out,
    output logic                     rd_valid
);

    // Range checks use one extra bit so DEPTH itself is representable
    localparam logic [ADDR_W:0]   c_depth_ext = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] c_last_ptr  = ADDR_W'(DEPTH - 1);

    clr_state_t              r_state;
    logic [ADDR_W-1:0]       r_ptr;
    logic                    r_s1_valid;
    logic [ADDR_W-1:0]       r_s1_addr;

    logic                    w_we;
    logic [ADDR_W-1:0]       w_waddr;
    logic signed [WIDTH-1:0] w_wdata;
    logic                    w_s1_oor;
    logic signed [WIDTH-1:0] w_core_data;
    logic                    w_core_valid;

    // ------------------------------------------------------------------
    // Clear sweep controller; reset starts a sweep so memory is always
    // defined after reset.
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= CLEAR;
            r_ptr   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (clear_req) begin
                        r_state <= CLEAR;
                        r_ptr   <= '0;
                    end
                end
                CLEAR: begin
                    if (r_ptr == c_last_ptr) begin
                        r_state <= IDLE;
                    end else begin
                        r_ptr <= r_ptr + 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign busy = (r_state == CLEAR);

    // ------------------------------------------------------------------
    // Write mux: the sweep owns the port while busy; external writes to
    // addresses beyond the array are dropped.
    // ------------------------------------------------------------------
    always_comb begin
        w_we    = 1'b0;
        w_waddr = wr_addr;
        w_wdata = data_in;
        if (busy) begin
            w_we    = 1'b1;
            w_waddr = r_ptr;
            w_wdata = CLEAR_VAL;
        end else if (wr_en && ({1'b0, wr_addr} < c_depth_ext)) begin
            w_we = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Read stage 1: requests are only accepted while idle. Requests
    // already in flight when a sweep starts still complete.
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            r_s1_valid <= 1'b0;
        end else begin
            r_s1_valid <= rd_en && !busy;
        end
        r_s1_addr <= rd_addr;
    end

    assign w_s1_oor = ({1'b0, r_s1_addr} >= c_depth_ext);

    ram_sdp_core #(
        .WIDTH  (WIDTH),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .BYPASS (BYPASS)
    ) u_core (
        .clock    (clock),
        .reset    (reset),
        .wr_en    (w_we),
        .wr_addr  (w_waddr),
        .wr_data  (w_wdata),
        .rd_en    (r_s1_valid),
        .rd_addr  (r_s1_addr),
        .rd_zero  (w_s1_oor),
        .rd_data  (w_core_data),
        .rd_valid (w_core_valid)
    );

    // ------------------------------------------------------------------
    // Optional output register; the core holds its data between reads,
    // so copying every cycle preserves the hold behaviour.
    // ------------------------------------------------------------------
    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic signed [WIDTH-1:0] r_dout;
            logic                    r_dvalid;

            always_ff @(posedge clock) begin
                if (reset) begin
                    r_dout   <= '0;
                    r_dvalid <= 1'b0;
                end else begin
                    r_dout   <= w_core_data;
                    r_dvalid <= w_core_valid;
                end
            end

            assign data_out = r_dout;
            assign rd_valid = r_dvalid;
        end else begin : g_no_out_reg
            assign data_out = w_core_data;
            assign rd_valid = w_core_valid;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_ram_sdp_clr.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ram_sdp_clr
//  Description : Self-checking bench for ram_sdp_clr. Two instances share one
//                stimulus stream: A is the default 1024x8 read-first
//                configuration, B is DEPTH=600 with output register,
//                write-first collisions and CLEAR_VAL=-1. Each instance is
//                compared every cycle against a behavioural model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_ram_sdp_clr;

    logic              clock = 1'b0;
    logic              reset;
    logic              clear_req;
    logic              wr_en;
    logic [9:0]        wr_addr;
    logic signed [7:0] data_in;
    logic              rd_en;
    logic [9:0]        rd_addr;

    logic              busy_a, busy_b;
    logic signed [7:0] dout_a, dout_b;
    logic              rv_a, rv_b;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    ram_sdp_clr #(
        .WIDTH(8), .DEPTH(1024), .OUT_REG(0), .BYPASS(0), .CLEAR_VAL(8'sd0)
    ) u_dut_a (
        .clock(clock), .reset(reset), .clear_req(clear_req), .busy(busy_a),
        .wr_en(wr_en), .wr_addr(wr_addr), .data_in(data_in),
        .rd_en(rd_en), .rd_addr(rd_addr), .data_out(dout_a), .rd_valid(rv_a)
    );

    ram_sdp_clr #(
        .WIDTH(8), .DEPTH(600), .OUT_REG(1), .BYPASS(1), .CLEAR_VAL(-8'sd1)
    ) u_dut_b (
        .clock(clock), .reset(reset), .clear_req(clear_req), .busy(busy_b),
        .wr_en(wr_en), .wr_addr(wr_addr), .data_in(data_in),
        .rd_en(rd_en), .rd_addr(rd_addr), .data_out(dout_b), .rd_valid(rv_b)
    );

    // ---------------- reference model ----------------
    function automatic int dep(input int k);
        return (k == 0) ? 1024 : 600;
    endfunction
    function automatic bit outreg(input int k);
        return (k == 1);
    endfunction
    function automatic bit fwd(input int k);
        return (k == 1);
    endfunction
    function automatic int clrv(input int k);
        return (k == 0) ? 0 : -1;
    endfunction

    int m_mem  [2][1024];
    int m_left [2];         // remaining sweep cycles; busy while > 0
    int m_ptr  [2];
    bit m_pv   [2];         // read accepted at the previous edge
    int m_pa   [2];
    int m_res  [2];         // result of the array read (held when idle)
    bit m_resv [2];
    int m_late [2];         // same result one edge later
    bit m_latev[2];

    task automatic model_edge(input int k);
        bit busy_now, hit;
        int wa, wd;
        if (reset) begin
            m_left[k] = dep(k); m_ptr[k] = 0; m_pv[k] = 0;
            m_res[k] = 0; m_resv[k] = 0; m_late[k] = 0; m_latev[k] = 0;
            return;
        end
        busy_now = (m_left[k] > 0);
        hit = 0; wa = 0; wd = 0;
        if (busy_now) begin
            hit = 1; wa = m_ptr[k]; wd = clrv(k);
        end else if (wr_en && int'(wr_addr) < dep(k)) begin
            hit = 1; wa = int'(wr_addr); wd = int'(data_in);
        end
        m_late[k]  = m_res[k];
        m_latev[k] = m_resv[k];
        m_resv[k]  = m_pv[k];
        if (m_pv[k]) begin
            if (m_pa[k] >= dep(k))                      m_res[k] = 0;
            else if (hit && wa == m_pa[k] && fwd(k))    m_res[k] = wd;
            else                                        m_res[k] = m_mem[k][m_pa[k]];
        end
        if (hit) m_mem[k][wa] = wd;
        m_pv[k] = rd_en && !busy_now;
        m_pa[k] = int'(rd_addr);
        if (busy_now) begin
            m_left[k]--; m_ptr[k]++;
        end else if (clear_req) begin
            m_left[k] = dep(k); m_ptr[k] = 0;
        end
    endtask

    // ---------------- checking ----------------
    task automatic check_eq(input string tag, input logic signed [31:0] obs,
                            input logic signed [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s @%0t: got %0d expected %0d", tag, $time, obs, exp);
        end
    endtask

    task automatic compare();
        check_eq("A.busy",     busy_a, (m_left[0] > 0));
        check_eq("A.rd_valid", rv_a,   m_resv[0]);
        check_eq("A.data_out", dout_a, m_res[0]);
        check_eq("B.busy",     busy_b, (m_left[1] > 0));
        check_eq("B.rd_valid", rv_b,   m_latev[1]);
        check_eq("B.data_out", dout_b, m_late[1]);
    endtask

    task automatic step();
        @(posedge clock);
        model_edge(0);
        model_edge(1);
        #1;
        compare();
    endtask

    task automatic cyc(input bit we, input int wa, input int wd,
                       input bit re, input int ra);
        wr_en   = we;
        wr_addr = 10'(wa);
        data_in = 8'(wd);
        rd_en   = re;
        rd_addr = 10'(ra);
        step();
        wr_en = 1'b0;
        rd_en = 1'b0;
    endtask

    function automatic int rnd_addr();
        return ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 1023))
                                           : int'($urandom_range(0, 31));
    endfunction

    initial begin
        reset = 1'b1; clear_req = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
        wr_addr = '0; rd_addr = '0; data_in = '0;
        for (int k = 0; k < 2; k++) begin
            m_left[k] = 0; m_ptr[k] = 0; m_pv[k] = 0; m_pa[k] = 0;
            m_res[k] = 0; m_resv[k] = 0; m_late[k] = 0; m_latev[k] = 0;
            for (int i = 0; i < 1024; i++) m_mem[k][i] = 0;
        end

        // Reset and the power-on sweep
        step(); step();
        reset = 1'b0;
        repeat (1030) step();

        // Cleared words, including the top address (out of range for B)
        cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 0, 1, 511);
        cyc(0, 0, 0, 1, 1023);
        repeat (4) step();

        // Write -5 then read it back the next cycle
        cyc(1, 17, -5, 0, 0);
        cyc(0, 0, 0, 1, 17);
        repeat (4) step();

        // Collision: read 40 at t, write 9 to 40 at t+1
        cyc(1, 40, 3, 0, 0);
        step();
        cyc(0, 0, 0, 1, 40);
        cyc(1, 40, 9, 0, 0);
        repeat (4) step();

        // Pipelined reads 0..7 after writing value=address
        for (int i = 0; i < 8; i++) cyc(1, i, i, 0, 0);
        for (int i = 0; i < 8; i++) cyc(0, 0, 0, 1, i);
        repeat (4) step();

        // Address 700: valid for A, dropped / zero-read for B
        cyc(1, 700, 55, 0, 0);
        cyc(0, 0, 0, 1, 700);
        repeat (4) step();

        // Randomised traffic with rare clear requests
        for (int n = 0; n < 2000; n++) begin
            clear_req = ($urandom_range(0, 699) == 0);
            cyc(1'($urandom_range(0, 1)), rnd_addr(), int'($urandom_range(0, 255)),
                1'($urandom_range(0, 1)), rnd_addr());
            clear_req = 1'b0;
        end
        repeat (1030) step();

        // Fill, then clear with writes and reads held high during the sweep
        for (int i = 0; i < 64; i++) cyc(1, i, int'($urandom_range(0, 255)), 1, i);
        clear_req = 1'b1;
        cyc(1, 5, 77, 1, 5);
        clear_req = 1'b0;
        for (int n = 0; n < 1030; n++)
            cyc(1, rnd_addr(), int'($urandom_range(0, 255)), 1, rnd_addr());
        for (int i = 0; i < 1024; i++) cyc(0, 0, 0, 1, i);
        repeat (4) step();

        // Reset in the middle of a sweep restarts it from word 0
        clear_req = 1'b1;
        step();
        clear_req = 1'b0;
        repeat (300) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        repeat (1030) step();
        for (int n = 0; n < 200; n++)
            cyc(1'($urandom_range(0, 1)), rnd_addr(), int'($urandom_range(0, 255)),
                1'($urandom_range(0, 1)), rnd_addr());
        repeat (4) step();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
